// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state encoding for the 8:1 mux round-robin arbiter
package mux_arb_pkg;

    localparam int N      = 8;
    localparam int SEL_W  = 3;
    localparam int HCNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface mux8_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [N-1:0]     req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     grant;
    logic             valid;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  valid
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output valid
    );

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick: rotate by ptr, priority-encode, un-rotate
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] idx,
    output logic       any
);

    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[7:0];
        off = 3'd0;
        // Descending scan so the lowest set bit (closest to ptr) wins.
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
        any = |rot;
        idx = ptr + off;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - registered round-robin arbiter driving the 8:1 mux select
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux8_rr_arbiter_if.slave   bus
);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              valid_q, valid_d;

    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              exit_now;

    // While granted, the pick already searches from sel+1 so a handover needs no bubble.
    assign pick_ptr = (state_q == GRANT) ? (sel_q + 3'd1) : ptr_q;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hcnt_d   = hcnt_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        exit_now = bus.done || !bus.req[sel_q] || (hcnt_q == HCNT_W'(MAX_HOLD - 1));

        if (state_q == IDLE) begin
            if (pick_any) begin
                state_d           = GRANT;
                sel_d             = pick_idx;
                grant_d           = '0;
                grant_d[pick_idx] = 1'b1;
                valid_d           = 1'b1;
                hcnt_d            = '0;
            end
        end else begin
            if (exit_now) begin
                ptr_d = sel_q + 3'd1;
                if (pick_any) begin
                    sel_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    hcnt_d            = '0;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    grant_d = '0;
                end
            end else begin
                hcnt_d = hcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;

endmodule
